// File: rtl/mouse_master_sm_if.sv
// Bus between the PS/2 mouse sequencer and its byte-level transmitter,
// receiver and packet consumer. The master modport is the sequencer side.
// MOUSE_ERR_CNT_EN adds the ERR_COUNT diagnostic output.
interface mouse_master_sm_if;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic [7:0] MOUSE_STATUS;
  logic [7:0] MOUSE_DX;
  logic [7:0] MOUSE_DY;
  logic       SEND_INTERRUPT;
  logic [3:0] MASTER_STATE;
`ifdef MOUSE_ERR_CNT_EN
  logic [7:0] ERR_COUNT;

  modport master (
    output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, MOUSE_STATUS, MOUSE_DX,
           MOUSE_DY, SEND_INTERRUPT, MASTER_STATE, ERR_COUNT,
    input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );
  modport slave (
    input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, MOUSE_STATUS, MOUSE_DX,
           MOUSE_DY, SEND_INTERRUPT, MASTER_STATE, ERR_COUNT,
    output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );
`else
  modport master (
    output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, MOUSE_STATUS, MOUSE_DX,
           MOUSE_DY, SEND_INTERRUPT, MASTER_STATE,
    input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );
  modport slave (
    input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, MOUSE_STATUS, MOUSE_DX,
           MOUSE_DY, SEND_INTERRUPT, MASTER_STATE,
    output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );
`endif
endinterface

// File: rtl/mouse_master_sm.sv
// PS/2 mouse top-level sequencer: runs the init handshake (FF / FA AA 00 /
// F4 / FA) and then assembles 3-byte movement packets into registered
// status/dx/dy outputs with a one-cycle interrupt per packet.
// Optional: MOUSE_ERR_CNT_EN adds a saturating ERR_COUNT output.
module mouse_master_sm #(
  parameter int STARTUP_CYCLES = 1_000_000,
  parameter int RESP_TIMEOUT   = 100_000_000,
  parameter int TIMER_W        = 27
) (
  input logic               CLK,
  input logic               RESET,
  mouse_master_sm_if.master bus
);

  typedef enum logic [3:0] {
    INIT_WAIT     = 4'd0,
    SEND_RESET    = 4'd1,
    WAIT_SENT_RST = 4'd2,
    WAIT_ACK1     = 4'd3,
    WAIT_SELFTEST = 4'd4,
    WAIT_ID       = 4'd5,
    SEND_ENABLE   = 4'd6,
    WAIT_SENT_EN  = 4'd7,
    WAIT_ACK2     = 4'd8,
    PKT_B0        = 4'd9,
    PKT_B1        = 4'd10,
    PKT_B2        = 4'd11
  } state_t;

  state_t             state, nxt;
  logic [TIMER_W-1:0] timer;
  logic [7:0]         status_sh, dx_sh;
  logic               send_byte, read_enable, send_irq;
  logic [7:0]         byte_to_send, status_q, dx_q, dy_q;
  logic               rdy, good, tmo, startup_done;
  logic               ld_status, ld_dx, ld_pkt;

  assign rdy          = bus.BYTE_READY;
  assign good         = bus.BYTE_READY && (bus.BYTE_ERROR_CODE == 2'b00);
  assign tmo          = (timer == TIMER_W'(RESP_TIMEOUT - 1));
  assign startup_done = (timer == TIMER_W'(STARTUP_CYCLES - 1));

  // Next-state and load strobes; a byte arriving always beats a timeout.
  always_comb begin
    nxt       = state;
    ld_status = 1'b0;
    ld_dx     = 1'b0;
    ld_pkt    = 1'b0;
    case (state)
      INIT_WAIT:     if (startup_done) nxt = SEND_RESET;
      SEND_RESET:    nxt = WAIT_SENT_RST;
      WAIT_SENT_RST: if (bus.BYTE_SENT) nxt = WAIT_ACK1;
                     else if (tmo) nxt = INIT_WAIT;
      WAIT_ACK1:     if (rdy) nxt = (good && bus.BYTE_READ == 8'hFA) ? WAIT_SELFTEST : INIT_WAIT;
                     else if (tmo) nxt = INIT_WAIT;
      WAIT_SELFTEST: if (rdy) nxt = (good && bus.BYTE_READ == 8'hAA) ? WAIT_ID : INIT_WAIT;
                     else if (tmo) nxt = INIT_WAIT;
      WAIT_ID:       if (rdy) nxt = (good && bus.BYTE_READ == 8'h00) ? SEND_ENABLE : INIT_WAIT;
                     else if (tmo) nxt = INIT_WAIT;
      SEND_ENABLE:   nxt = WAIT_SENT_EN;
      WAIT_SENT_EN:  if (bus.BYTE_SENT) nxt = WAIT_ACK2;
                     else if (tmo) nxt = INIT_WAIT;
      WAIT_ACK2:     if (rdy) nxt = (good && bus.BYTE_READ == 8'hFA) ? PKT_B0 : INIT_WAIT;
                     else if (tmo) nxt = INIT_WAIT;
      // Bit 3 is always set in a status byte; anything else is a resync discard.
      PKT_B0:        if (good && bus.BYTE_READ[3]) begin
                       nxt       = PKT_B1;
                       ld_status = 1'b1;
                     end
      PKT_B1:        if (good) begin
                       nxt   = PKT_B2;
                       ld_dx = 1'b1;
                     end else if (rdy || tmo) nxt = PKT_B0;
      PKT_B2:        if (good) begin
                       nxt    = PKT_B0;
                       ld_pkt = 1'b1;
                     end else if (rdy || tmo) nxt = PKT_B0;
      default:       nxt = INIT_WAIT;
    endcase
  end

  // State register and per-state timer (cleared on every transition).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= INIT_WAIT;
      timer <= '0;
    end else begin
      state <= nxt;
      timer <= (nxt != state) ? '0 : timer + TIMER_W'(1);
    end
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      send_byte    <= 1'b0;
      byte_to_send <= 8'h00;
      read_enable  <= 1'b0;
      send_irq     <= 1'b0;
      status_sh    <= 8'h00;
      dx_sh        <= 8'h00;
      status_q     <= 8'h00;
      dx_q         <= 8'h00;
      dy_q         <= 8'h00;
    end else begin
      send_byte   <= (nxt == SEND_RESET) || (nxt == SEND_ENABLE);
      read_enable <= (nxt inside {WAIT_ACK1, WAIT_SELFTEST, WAIT_ID, WAIT_ACK2,
                                  PKT_B0, PKT_B1, PKT_B2});
      send_irq    <= ld_pkt;
      if (nxt == SEND_RESET)  byte_to_send <= 8'hFF;
      if (nxt == SEND_ENABLE) byte_to_send <= 8'hF4;
      if (ld_status) status_sh <= bus.BYTE_READ;
      if (ld_dx)     dx_sh     <= bus.BYTE_READ;
      if (ld_pkt) begin
        status_q <= status_sh;
        dx_q     <= dx_sh;
        dy_q     <= bus.BYTE_READ;
      end
    end
  end

  assign bus.SEND_BYTE      = send_byte;
  assign bus.BYTE_TO_SEND   = byte_to_send;
  assign bus.READ_ENABLE    = read_enable;
  assign bus.SEND_INTERRUPT = send_irq;
  assign bus.MOUSE_STATUS   = status_q;
  assign bus.MOUSE_DX       = dx_q;
  assign bus.MOUSE_DY       = dy_q;
  assign bus.MASTER_STATE   = state;

`ifdef MOUSE_ERR_CNT_EN
  logic       err_inc;
  logic [7:0] err_cnt;

  // Error events: stream discards/timeouts and any fall-back to full re-init.
  always_comb begin
    err_inc = 1'b0;
    case (state)
      PKT_B0:         err_inc = rdy && !(good && bus.BYTE_READ[3]);
      PKT_B1, PKT_B2: err_inc = (rdy && !good) || (!rdy && tmo);
      default:        err_inc = 1'b0;
    endcase
    if ((state inside {[WAIT_SENT_RST:WAIT_ACK2]}) && nxt == INIT_WAIT) err_inc = 1'b1;
  end

  // Saturating error counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) err_cnt <= 8'h00;
    else if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
  end

  assign bus.ERR_COUNT = err_cnt;
`else
`endif

endmodule

// File: tb/tb_mouse_master_sm.sv
// Scoreboard bench for mouse_master_sm: expected commands and packets are
// queued by the stimulus, a negedge monitor pops them as the DUT emits them.
module tb_mouse_master_sm;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  mouse_master_sm_if bus();

  mouse_master_sm #(.STARTUP_CYCLES(20), .RESP_TIMEOUT(200), .TIMER_W(27)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_cmd[$];
  logic [23:0] exp_pkt[$];
  bit         tx_mute = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Transmitter model: BYTE_SENT five cycles after each SEND_BYTE.
  initial begin
    bus.BYTE_SENT = 1'b0;
    forever begin
      @(negedge CLK);
      if (bus.SEND_BYTE === 1'b1 && !tx_mute) begin
        repeat (4) @(posedge CLK);
        #1 bus.BYTE_SENT = 1'b1;
        @(posedge CLK);
        #1 bus.BYTE_SENT = 1'b0;
      end
    end
  end

  // Monitor: every command and every interrupt must match a queued expectation.
  initial begin
    logic [7:0]  ec;
    logic [23:0] ep;
    forever begin
      @(negedge CLK);
      if (bus.SEND_BYTE === 1'b1) begin
        if (exp_cmd.size() == 0) begin
          total++; bad++;
          $display("FAIL unexp_send got=%0h required=none", bus.BYTE_TO_SEND);
        end else begin
          ec = exp_cmd.pop_front();
          check("send_byte", bus.BYTE_TO_SEND, ec);
        end
      end
      if (bus.SEND_INTERRUPT === 1'b1) begin
        if (exp_pkt.size() == 0) begin
          total++; bad++;
          $display("FAIL unexp_irq got=%0h required=none",
                   {bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY});
        end else begin
          ep = exp_pkt.pop_front();
          check("packet", {bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY}, ep);
        end
      end
    end
  end

  task automatic rx(input logic [7:0] b, input logic [1:0] c);
    @(posedge CLK);
    #1;
    bus.BYTE_READ = b;
    bus.BYTE_ERROR_CODE = c;
    bus.BYTE_READY = 1'b1;
    @(posedge CLK);
    #1 bus.BYTE_READY = 1'b0;
  endtask

  task automatic wait_state(input string nm, input logic [3:0] s, input int budget);
    int n = 0;
    while (bus.MASTER_STATE !== s && n < budget) begin
      @(posedge CLK); #1; n++;
    end
    check(nm, bus.MASTER_STATE, s);
  endtask

  // Count edges until state s is reached and compare with the exact latency.
  task automatic cycles_to_state(input string nm, input logic [3:0] s, input int exp, input int budget);
    int n = 0;
    do begin
      @(posedge CLK); #1; n++;
    end while (bus.MASTER_STATE !== s && n < budget);
    check(nm, n, exp);
  endtask

  // The reset command must go out exactly 20 cycles after entering INIT_WAIT.
  task automatic cycles_to_send(input string nm);
    int n = 0;
    do begin
      @(posedge CLK); #1; n++;
    end while (bus.SEND_BYTE !== 1'b1 && n < 60);
    check(nm, n, 20);
    check({nm, "_st"}, bus.MASTER_STATE, 4'd1);
  endtask

  task automatic init_seq(input string nm);
    exp_cmd.push_back(8'hFF);
    exp_cmd.push_back(8'hF4);
    cycles_to_send(nm);
    wait_state({nm, "_ack1"}, 4'd3, 20);
    rx(8'hFA, 2'b00);
    check({nm, "_st4"}, bus.MASTER_STATE, 4'd4);
    rx(8'hAA, 2'b00);
    check({nm, "_st5"}, bus.MASTER_STATE, 4'd5);
    rx(8'h00, 2'b00);
    wait_state({nm, "_ack2"}, 4'd8, 20);
    rx(8'hFA, 2'b00);
    check({nm, "_st9"}, bus.MASTER_STATE, 4'd9);
    check({nm, "_rden"}, bus.READ_ENABLE, 1'b1);
  endtask

  initial begin
    #200000;
    total++; bad++;
    $display("FAIL watchdog got=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bus.BYTE_READ = 8'h00;
    bus.BYTE_ERROR_CODE = 2'b00;
    bus.BYTE_READY = 1'b0;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_state", bus.MASTER_STATE, 4'd0);
    check("rst_outs", {bus.SEND_BYTE, bus.READ_ENABLE, bus.SEND_INTERRUPT, bus.BYTE_TO_SEND}, 0);
    check("rst_pkt", {bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY}, 0);
    @(negedge CLK) RESET = 1'b0;

    // Clean init
    init_seq("init");

    // First packet and its one-cycle latency
    exp_pkt.push_back(24'h0805FB);
    rx(8'h08, 2'b00);
    rx(8'h05, 2'b00);
    rx(8'hFB, 2'b00);
    check("irq_lat", bus.SEND_INTERRUPT, 1'b1);
    check("pkt1_outs", {bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY}, 24'h0805FB);
    @(posedge CLK); #1;
    check("irq_pulse", bus.SEND_INTERRUPT, 1'b0);

    // Resync discard, then a parity error mid-packet
    rx(8'h05, 2'b00);
    check("resync_st", bus.MASTER_STATE, 4'd9);
    rx(8'h18, 2'b00);
    check("b0_st", bus.MASTER_STATE, 4'd10);
    rx(8'h02, 2'b01);
    check("err_st", bus.MASTER_STATE, 4'd9);
    check("err_hold", {bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY}, 24'h0805FB);
    exp_pkt.push_back(24'h180203);
    rx(8'h18, 2'b00);
    rx(8'h02, 2'b00);
    rx(8'h03, 2'b00);
    check("pkt2_outs", {bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY}, 24'h180203);
`ifdef MOUSE_ERR_CNT_EN
    check("err_count", bus.ERR_COUNT, 8'd2);
`endif
    repeat (2) @(posedge CLK);

    // Init fault: wrong ACK
    @(negedge CLK) RESET = 1'b1;
    @(negedge CLK) RESET = 1'b0;
    exp_cmd.push_back(8'hFF);
    cycles_to_send("rst2");
    wait_state("f_ack1", 4'd3, 20);
    rx(8'hFE, 2'b00);
    check("bad_ack_st", bus.MASTER_STATE, 4'd0);
    exp_cmd.push_back(8'hFF);
    cycles_to_send("refault");

    // Init fault: F4 never acknowledged by the transmitter
    wait_state("f2_ack1", 4'd3, 20);
    rx(8'hFA, 2'b00);
    rx(8'hAA, 2'b00);
    tx_mute = 1'b1;
    exp_cmd.push_back(8'hF4);
    rx(8'h00, 2'b00);
    wait_state("f2_st7", 4'd7, 10);
    cycles_to_state("tx_tmo", 4'd0, 200, 300);
    tx_mute = 1'b0;
    init_seq("reinit");

    // Mid-packet timeout
    rx(8'h08, 2'b00);
    check("mt_st10", bus.MASTER_STATE, 4'd10);
    cycles_to_state("pkt_tmo", 4'd9, 200, 300);

    // Byte lands on the timeout cycle: the byte wins
    rx(8'h08, 2'b00);
    repeat (198) @(posedge CLK);
    rx(8'h05, 2'b00);
    check("prio_st", bus.MASTER_STATE, 4'd11);
    exp_pkt.push_back(24'h080507);
    rx(8'h07, 2'b00);
    check("pkt3_outs", {bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY}, 24'h080507);
    repeat (2) @(posedge CLK);

    // Short asynchronous reset in PKT_B2
    rx(8'h08, 2'b00);
    rx(8'h01, 2'b00);
    check("ar_st11", bus.MASTER_STATE, 4'd11);
    @(posedge CLK);
    #2 RESET = 1'b1;
    #2;
    check("ar_state", bus.MASTER_STATE, 4'd0);
    check("ar_outs", {bus.SEND_BYTE, bus.READ_ENABLE, bus.SEND_INTERRUPT, bus.BYTE_TO_SEND}, 0);
    check("ar_pkt", {bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY}, 0);
`ifdef MOUSE_ERR_CNT_EN
    check("ar_errcnt", bus.ERR_COUNT, 8'd0);
`endif
    RESET = 1'b0;
    init_seq("post_rst");

    repeat (3) @(posedge CLK);
    #1;
    check("cmd_q_empty", exp_cmd.size(), 0);
    check("pkt_q_empty", exp_pkt.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
